// File: rtl/uart_pkg.sv
// Shared definitions for the host command link receive path: receiver states,
// default bit timing and the protocol bytes the downstream parser recognises.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_e;

  // 50 MHz system clock, 115200 baud
  localparam int UART_DEFAULT_CLKS_PER_BIT = 434;

  localparam logic [7:0] S = 8'h53;
  localparam logic [7:0] T = 8'h54;
  localparam logic [7:0] E = 8'h45;
  localparam logic [7:0] N = 8'h4E;
  localparam logic [7:0] D = 8'h44;

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer with asynchronous active-low reset and a
// configurable reset value.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver, LSB first. Oversamples the synchronized line, samples each
// bit at its centre and reports good bytes or framing errors as one-cycle pulses.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Frame_Err,
  output logic       o_Busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  uart_state_e   state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    idx, idx_nxt;
  logic [7:0]    shift, shift_nxt;
  logic [7:0]    byte_nxt;
  logic          dv_nxt, err_nxt;
  logic          rx_s;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk  (i_Clk),
    .rst_n(i_Rst_n),
    .d    (i_Rx_Serial),
    .q    (rx_s)
  );

  // Output handshake: o_Rx_DV is a valid-only strobe with no ready. The byte on
  // o_Rx_Byte is valid in the DV cycle and stays stable until the next DV.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    idx_nxt   = idx;
    shift_nxt = shift;
    byte_nxt  = o_Rx_Byte;
    dv_nxt    = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!rx_s) state_nxt = START;
      end
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_nxt   = '0;
          idx_nxt   = 3'd0;
          state_nxt = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt        = '0;
          shift_nxt[idx] = rx_s;
          if (idx == 3'd7) state_nxt = STOP;
          else             idx_nxt   = idx + 3'd1;
        end
      end
      STOP: begin
        // Leaving mid stop bit lets a start edge right after the frame be caught.
        if (cnt == CNT_LAST) begin
          cnt_nxt = '0;
          if (rx_s) begin
            byte_nxt  = shift;
            dv_nxt    = 1'b1;
            state_nxt = IDLE;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = BREAK;
          end
        end
      end
      BREAK: begin
        cnt_nxt = '0;
        if (rx_s) state_nxt = IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= 3'd0;
      shift       <= 8'h00;
      o_Rx_Byte   <= 8'h00;
      o_Rx_DV     <= 1'b0;
      o_Frame_Err <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      idx         <= idx_nxt;
      shift       <= shift_nxt;
      o_Rx_Byte   <= byte_nxt;
      o_Rx_DV     <= dv_nxt;
      o_Frame_Err <= err_nxt;
    end
  end

  assign o_Busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at 8 clocks per bit: frames are driven on the
// line, and a per-cycle compare process checks pulses and the held byte.
module tb_uart_rx_byte;
  import uart_pkg::*;

  localparam int CPB   = 8;
  localparam int CLK_P = 10;
  localparam int BIT_T = CPB * CLK_P;
  // 2 sync cycles + 1 idle detect + stop sample offset from START + 1 output register
  localparam int DV_LAT = 2 + 1 + (9 * CPB + (CPB - 1) / 2) + 1;

  logic       i_Clk = 1'b0;
  logic       i_Rst_n;
  logic       i_Rx_Serial;
  logic       o_Rx_DV;
  logic [7:0] o_Rx_Byte;
  logic       o_Frame_Err;
  logic       o_Busy;

  uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clk      (i_Clk),
    .i_Rst_n    (i_Rst_n),
    .i_Rx_Serial(i_Rx_Serial),
    .o_Rx_DV    (o_Rx_DV),
    .o_Rx_Byte  (o_Rx_Byte),
    .o_Frame_Err(o_Frame_Err),
    .o_Busy     (o_Busy)
  );

  // clock/reset block
  always #(CLK_P / 2) i_Clk = ~i_Clk;

  int cyc = 0;
  always @(posedge i_Clk) cyc <= cyc + 1;

  // scoreboard state: {is_frame_error, byte} plus the cycle its pulse is due
  logic [8:0] exp_q[$];
  int         due_q[$];
  logic [7:0] model_byte = 8'h00;
  logic [8:0] e_ent;
  int         d_ent;
  int         n_checks = 0;
  int         n_fail   = 0;
  int         dv_cnt   = 0;
  int         err_cnt  = 0;
  bit         track_busy = 1'b0;
  int         low_run  = 0;
  int         max_low  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_win(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
    end
  endtask

  // driver tasks
  task automatic align();
    @(posedge i_Clk);
    #(CLK_P - 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge i_Clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input int bit_t, input logic stop_v);
    exp_q.push_back({~stop_v, b});
    due_q.push_back(cyc + DV_LAT);
    i_Rx_Serial = 1'b0;
    #(bit_t);
    for (int i = 0; i < 8; i++) begin
      i_Rx_Serial = b[i];
      #(bit_t);
    end
    i_Rx_Serial = stop_v;
    #(bit_t);
  endtask

  task automatic wait_drain(input int max_cyc);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < max_cyc) begin
      @(negedge i_Clk);
      k++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  // compare process
  always @(negedge i_Clk) begin
    if (!i_Rst_n) begin
      model_byte = 8'h00;
    end else begin
      check("pulse_excl", o_Rx_DV & o_Frame_Err, 1'b0);
      if (o_Rx_DV || o_Frame_Err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {o_Rx_DV, o_Frame_Err}, 2'b00);
        end else begin
          e_ent = exp_q.pop_front();
          d_ent = due_q.pop_front();
          check("pulse_kind", o_Frame_Err, e_ent[8]);
          check_win("pulse_time", cyc, d_ent - 1, d_ent + 1);
          if (o_Rx_DV) begin
            dv_cnt++;
            model_byte = e_ent[7:0];
          end else begin
            err_cnt++;
          end
        end
      end else if (due_q.size() != 0 && cyc > due_q[0] + 1) begin
        check("missing_pulse", o_Rx_DV | o_Frame_Err, 1'b1);
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
      end
      check("rx_byte", o_Rx_Byte, model_byte);
      if (track_busy) begin
        if (!o_Busy) low_run++;
        else         low_run = 0;
        if (low_run > max_low) max_low = low_run;
      end
    end
  end

  initial begin
    logic [7:0] stream [7];
    int         hi_cnt;
    int         last_hi;

    stream = '{S, T, 8'h01, 8'h64, E, N, D};
    i_Rst_n     = 1'b0;
    i_Rx_Serial = 1'b1;
    #23;
    check("rst_dv",   o_Rx_DV,     1'b0);
    check("rst_err",  o_Frame_Err, 1'b0);
    check("rst_busy", o_Busy,      1'b0);
    check("rst_byte", o_Rx_Byte,   8'h00);
    i_Rst_n = 1'b1;
    idle(5);

    // 1: single byte
    align();
    send_frame(S, BIT_T, 1'b1);
    wait_drain(200);
    idle(5);
    check("t1_dv_count", dv_cnt, 1);
    check("t1_err_count", err_cnt, 0);
    check("t1_byte", o_Rx_Byte, 8'h53);

    // 2: back-to-back stream, no idle gap
    low_run    = 0;
    max_low    = 0;
    track_busy = 1'b1;
    align();
    for (int i = 0; i < 7; i++) send_frame(stream[i], BIT_T, 1'b1);
    wait_drain(200);
    track_busy = 1'b0;
    idle(5);
    check("t2_dv_count", dv_cnt, 8);
    check("t2_err_count", err_cnt, 0);
    check("t2_last_byte", o_Rx_Byte, 8'h44);
    check_win("t2_busy_gap", max_low, 0, CPB);

    // 3: 3-cycle glitch
    align();
    i_Rx_Serial = 1'b0;
    #(3 * CLK_P);
    i_Rx_Serial = 1'b1;
    hi_cnt  = 0;
    last_hi = -1;
    for (int i = 0; i < 16; i++) begin
      @(negedge i_Clk);
      if (o_Busy) begin
        hi_cnt++;
        last_hi = i;
      end
    end
    check_win("t3_busy_seen", hi_cnt, 1, 8);
    check_win("t3_busy_drop", last_hi, 0, 7);
    check("t3_dv_count", dv_cnt, 8);
    check("t3_err_count", err_cnt, 0);

    // 4: framing error with held-low line, then recovery
    align();
    send_frame(8'h3C, BIT_T, 1'b1);
    send_frame(8'hA5, BIT_T, 1'b0);
    #(20 * CLK_P);
    i_Rx_Serial = 1'b1;
    wait_drain(200);
    idle(10);
    check("t4_err_count", err_cnt, 1);
    check("t4_dv_count", dv_cnt, 9);
    check("t4_byte_kept", o_Rx_Byte, 8'h3C);
    align();
    send_frame(8'h7E, BIT_T, 1'b1);
    wait_drain(200);
    idle(5);
    check("t4_recover_byte", o_Rx_Byte, 8'h7E);
    check("t4_recover_count", dv_cnt, 10);

    // 5: reset during data bit 4 of 8'hFF
    align();
    i_Rx_Serial = 1'b0;
    #(BIT_T);
    i_Rx_Serial = 1'b1;
    #(4 * BIT_T + BIT_T / 2 + 4);
    check("t5_busy_before", o_Busy, 1'b1);
    i_Rst_n = 1'b0;
    #1;
    check("t5_rst_dv",   o_Rx_DV,     1'b0);
    check("t5_rst_err",  o_Frame_Err, 1'b0);
    check("t5_rst_busy", o_Busy,      1'b0);
    check("t5_rst_byte", o_Rx_Byte,   8'h00);
    #(3 * CLK_P);
    i_Rst_n = 1'b1;
    idle(10);
    check("t5_idle_busy", o_Busy, 1'b0);
    align();
    send_frame(8'h0F, BIT_T, 1'b1);
    wait_drain(200);
    idle(5);
    check("t5_byte", o_Rx_Byte, 8'h0F);
    check("t5_dv_count", dv_cnt, 11);

    // 6: baud tolerance, 8.5 and 7.5 clocks per bit
    align();
    send_frame(8'hC3, BIT_T + CLK_P / 2, 1'b1);
    wait_drain(200);
    idle(10);
    check("t6_slow_byte", o_Rx_Byte, 8'hC3);
    check("t6_slow_count", dv_cnt, 12);
    align();
    send_frame(8'hC3, BIT_T - CLK_P / 2, 1'b1);
    wait_drain(200);
    idle(10);
    check("t6_fast_byte", o_Rx_Byte, 8'hC3);
    check("t6_fast_count", dv_cnt, 13);
    check("final_err_count", err_cnt, 1);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
